fp_operand_unpack: RTL
======================

// Module: fp_operand_unpack
// PURPOSE
//  Front-end decoder for the FP adder: the inverse of the pack stage. Takes two IEEE-754 single words,
//  splits them into sign/exponent/24-bit significand (hidden bit restored), classifies each operand and
//  orders them so X is the larger magnitude. Two-stage valid/ready pipeline feeding the align stage.
// PARAMETERS
//  FLUSH_DENORM  0  1: denormal inputs decode as zero (class ZERO, mant 0, exp field 0)
//  SWAP_EN       1  0: never swap; X=A, Y=B, swapped=0, expDiff=|effExpA-effExpB|
// PORTS
//  clk        in   1   clock; all state updates on rising edge
//  rst_n      in   1   reset, synchronous, active-low
//  in_valid   in   1   A/B valid
//  in_ready   out  1   block accepts A/B this cycle
//  A, B       in   32  IEEE-754 single operands
//  out_valid  out  1   decoded pair valid
//  out_ready  in   1   downstream accepts this cycle
//  signX/Y    out  1   sign of larger / smaller-magnitude operand
//  expX/Y     out  8   effective exponent (field, or 1 if field==0)
//  mantX/Y    out  24  {hidden,fraction}; hidden=1 iff exp field != 0
//  classX/Y   out  3   0 ZERO,1 DENORM,2 NORMAL,3 INF,4 QNAN,5 SNAN
//  expDiff    out  8   expX - expY (unsigned, never negative)
//  swapped    out  1   1 if X came from B
//  special    out  1   either operand INF or NaN
// BEHAVIOUR
//  - Handshake: transfer on valid&ready at each end. Data held stable while out_valid & !out_ready.
//  - Stage 1 registers raw A,B. Stage 2 registers decoded/ordered fields. Latency 2 cycles from
//    input transfer to out_valid; throughput 1 pair/cycle when out_ready=1.
//  - s2 loads when s1_valid & (!s2_valid | out_ready). s1 loads when in_valid & in_ready.
//  - in_ready = !s1_valid | !s2_valid | out_ready (combinational; in_ready=1 with both stages full
//    and out_ready=1 -- full-rate flow-through).
//  - Capacity 2 pairs; third pair stalls (in_ready=0) while out_ready=0. Order always preserved.
//  - Classification on exp field e, fraction f: e=0,f=0 ZERO; e=0,f!=0 DENORM; 0<e<255 NORMAL;
//    e=255,f=0 INF; e=255,f[22]=1 QNAN; e=255,f[22]=0,f!=0 SNAN.
//  - Effective exponent = (e==0)?1:e for ZERO and DENORM. FLUSH_DENORM=1: DENORM -> ZERO, mant 0, exp 1.
//  - Ordering: compare bits[30:0] unsigned; swap iff B[30:0] > A[30:0]; ties (incl. +0/-0) no swap.
//    Sign does not affect ordering. NaN/INF ordered by the same rule.
//  - special = class in {INF,QNAN,SNAN} for either operand; fields still decoded normally.
//  - Reset (rst_n=0 at edge): s1_valid=s2_valid=0, all data regs 0; outputs: out_valid=0, all data
//    outputs 0, in_ready=1 (combinational from cleared valids). In-flight pairs discarded; an input
//    presented during the reset cycle is not captured.
//  - out_valid never depends combinationally on out_ready. No X propagation after reset.
// TESTING
//  1. A=0x3F800000,B=0x40000000,out_ready=1 -> 2 clk later: swapped=1,expX=0x80,mantX=0x800000,
//     expY=0x7F,mantY=0x800000,expDiff=1,classX=classY=NORMAL.
//  2. A=0x00000001,B=0x00000000 (FLUSH_DENORM=0) -> classX=DENORM,expX=1,mantX=0x000001,classY=ZERO,
//     expDiff=0,swapped=0; FLUSH_DENORM=1 -> classX=ZERO,mantX=0.
//  3. out_ready=0, push pairs P0,P1,P2 back-to-back -> P0,P1 accepted, in_ready=0 on P2; out holds P0
//     stable; out_ready=1 -> P0,P1,P2 emerge in order on consecutive cycles, no loss/duplication.
//  4. A=0x7FC00000,B=0x7F800001 -> classA-side QNAN, SNAN other, special=1; A=0x7F800000 -> INF.
//  5. Both stages full, rst_n=0 one clk -> next cycle out_valid=0, in_ready=1, all data outputs 0.
//  6. A=0x40400000,B=0xC0400000 -> swapped=0,signX=0,signY=1,expDiff=0; SWAP_EN=0 with A=1.0,
//     B=2.0 -> X=A, swapped=0, expDiff=1.

Source files
------------

// File: rtl/fp_operand_unpack.sv
// Front-end decoder for the FP adder: splits two IEEE-754 singles into sign/exponent/significand,
// classifies them and orders them so X is the larger magnitude, through a 2-stage valid/ready pipe.
module fp_operand_unpack #(
  parameter bit FLUSH_DENORM = 1'b0,
  parameter bit SWAP_EN      = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        signX,
  output logic        signY,
  output logic [7:0]  expX,
  output logic [7:0]  expY,
  output logic [23:0] mantX,
  output logic [23:0] mantY,
  output logic [2:0]  classX,
  output logic [2:0]  classY,
  output logic [7:0]  expDiff,
  output logic        swapped,
  output logic        special
);

  typedef enum logic [2:0] {
    CLS_ZERO   = 3'd0,
    CLS_DENORM = 3'd1,
    CLS_NORMAL = 3'd2,
    CLS_INF    = 3'd3,
    CLS_QNAN   = 3'd4,
    CLS_SNAN   = 3'd5
  } fp_class_e;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] mant;
    fp_class_e   cls;
  } operand_t;

  function automatic operand_t decode(input logic [31:0] w);
    operand_t   o;
    logic [7:0]  e;
    logic [22:0] f;
    e      = w[30:23];
    f      = w[22:0];
    o.sign = w[31];
    o.exp  = (e == 8'd0) ? 8'd1 : e;
    o.mant = {(e != 8'd0), f};
    if (e == 8'd0) begin
      if (f == 23'd0) begin
        o.cls = CLS_ZERO;
      end else if (FLUSH_DENORM) begin
        o.cls  = CLS_ZERO;
        o.mant = '0;
      end else begin
        o.cls = CLS_DENORM;
      end
    end else if (e == 8'hFF) begin
      if (f == 23'd0)  o.cls = CLS_INF;
      else if (f[22])  o.cls = CLS_QNAN;
      else             o.cls = CLS_SNAN;
    end else begin
      o.cls = CLS_NORMAL;
    end
    return o;
  endfunction

  logic        s1_valid_q, s1_valid_d;
  logic        s2_valid_q, s2_valid_d;
  logic [31:0] a_q, b_q;
  operand_t    x_q, y_q;
  logic [7:0]  diff_q;
  logic        swapped_q, special_q;

  logic        s1_load, s2_load;
  operand_t    op_a, op_b, x_d, y_d;
  logic [7:0]  diff_d;
  logic        swap_d, special_d;

  // Stage 1 is free whenever stage 2 is empty or draining, so a full pipe still flows at full rate.
  assign in_ready = !s1_valid_q || !s2_valid_q || out_ready;
  assign s1_load  = in_valid && in_ready;
  assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);

  // NOTE: every signal written here gets a value before any branch, so no latch can be inferred.
  always_comb begin
    s1_valid_d = s1_valid_q;
    if (s2_load) s1_valid_d = 1'b0;
    if (s1_load) s1_valid_d = 1'b1;

    s2_valid_d = s2_valid_q;
    if (out_ready) s2_valid_d = 1'b0;
    if (s2_load)   s2_valid_d = 1'b1;

    op_a      = decode(a_q);
    op_b      = decode(b_q);
    swap_d    = SWAP_EN && (b_q[30:0] > a_q[30:0]);
    x_d       = swap_d ? op_b : op_a;
    y_d       = swap_d ? op_a : op_b;
    diff_d    = (x_d.exp >= y_d.exp) ? (x_d.exp - y_d.exp) : (y_d.exp - x_d.exp);
    special_d = (op_a.cls inside {CLS_INF, CLS_QNAN, CLS_SNAN}) ||
                (op_b.cls inside {CLS_INF, CLS_QNAN, CLS_SNAN});
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      x_q        <= '0;
      y_q        <= '0;
      diff_q     <= '0;
      swapped_q  <= 1'b0;
      special_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (s1_load) begin
        a_q <= A;
        b_q <= B;
      end
      if (s2_load) begin
        x_q       <= x_d;
        y_q       <= y_d;
        diff_q    <= diff_d;
        swapped_q <= swap_d;
        special_q <= special_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign signX     = x_q.sign;
  assign signY     = y_q.sign;
  assign expX      = x_q.exp;
  assign expY      = y_q.exp;
  assign mantX     = x_q.mant;
  assign mantY     = y_q.mant;
  assign classX    = x_q.cls;
  assign classY    = y_q.cls;
  assign expDiff   = diff_q;
  assign swapped   = swapped_q;
  assign special   = special_q;

endmodule
